// File: rtl/ticket_pkg.sv
// Shared definitions for the ticket barcode generator and reader.
package ticket_pkg;

   // Payload layout, MSB first on the wire
   localparam int unsigned PAYLOAD_W    = 16;
   localparam int unsigned CLIENT_W     = 2;
   localparam int unsigned DURATION_W   = 3;
   localparam int unsigned VALUE_W      = 5;
   localparam int unsigned EXCESS_W     = 6;
   localparam int unsigned CLIENT_LSB   = 14;
   localparam int unsigned DURATION_LSB = 11;
   localparam int unsigned VALUE_LSB    = 6;
   localparam int unsigned EXCESS_LSB   = 0;

   // Frame guards, first bit on the wire = MSB
   localparam logic [2:0] START_PAT = 3'b101;
   localparam logic [2:0] STOP_PAT  = 3'b101;

   // ErrorCode values
   localparam logic [1:0] ERR_PARITY  = 2'b01;
   localparam logic [1:0] ERR_STOP    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StPayload,
      StParity,
      StStop
   } state_t;

endpackage

// File: rtl/ticket_timeout_counter.sv
// Stall detector: counts enabled cycles since the last clear and pulses expire_o
// on the cycle that would complete TIMEOUT_CYC idle cycles.
module ticket_timeout_counter #(
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

   logic [CntW-1:0] count_q, count_d;

   // Clear wins over counting so a strobe on the expiry cycle restarts the count
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 1'b1;
      end
   end

   assign expire_o = enable_i && !clear_i && (count_q == LastCnt);

   // Count register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/barcode_ticket_reader.sv
// Rebuilds ticket fields from the scanned bar/space bit stream; checks guards,
// parity and aborts stalled scans.
module barcode_ticket_reader
   import ticket_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  BitIn,
   input  logic                  BitValid,
   output logic [CLIENT_W-1:0]   Client,
   output logic [DURATION_W-1:0] Duration,
   output logic [VALUE_W-1:0]    ValueToPay,
   output logic [EXCESS_W-1:0]   Excess5,
   output logic                  FrameValid,
   output logic                  FrameError,
   output logic [1:0]            ErrorCode,
   output logic                  Busy
);

   localparam int unsigned CntW = $clog2(PAYLOAD_W);

   state_t                 state_q, state_d;
   logic [2:0]             win_q, win_d;      // start window in idle, stop guard in StStop
   logic [2:0]             win_shift;
   logic [PAYLOAD_W-1:0]   shift_q, shift_d;
   logic [PAYLOAD_W-1:0]   payload_q, payload_d; // last good payload
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   par_err_q, par_err_d;
   logic                   frame_valid_q, frame_valid_d;
   logic                   frame_error_q, frame_error_d;
   logic [1:0]             err_code_q, err_code_d;
   logic                   expire;

   assign win_shift = {win_q[1:0], BitIn};

   ticket_timeout_counter #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk_i    (Clk),
      .rst_ni   (Reset_n),
      .clear_i  (BitValid || (state_q == StIdle)),
      .enable_i (state_q != StIdle),
      .expire_o (expire)
   );

   // Frame FSM next state, shift registers and result capture
   always_comb begin
      state_d       = state_q;
      win_d         = win_q;
      shift_d       = shift_q;
      payload_d     = payload_q;
      cnt_d         = cnt_q;
      par_err_d     = par_err_q;
      frame_valid_d = 1'b0;
      frame_error_d = 1'b0;
      err_code_d    = err_code_q;

      unique case (state_q)
         StIdle: begin
            if (BitValid) begin
               win_d = win_shift;
               if (win_shift == START_PAT) begin
                  state_d = StPayload;
                  win_d   = '0;
                  cnt_d   = '0;
               end
            end
         end
         StPayload: begin
            if (BitValid) begin
               shift_d = {shift_q[PAYLOAD_W-2:0], BitIn};
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CntW'(PAYLOAD_W - 1)) begin
                  state_d = StParity;
                  cnt_d   = '0;
               end
            end
         end
         StParity: begin
            if (BitValid) begin
               par_err_d = BitIn != (^shift_q);
               state_d   = StStop;
            end
         end
         StStop: begin
            if (BitValid) begin
               win_d = win_shift;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntW'(2)) begin
                  state_d = StIdle;
                  win_d   = '0;
                  cnt_d   = '0;
                  // Stop guard error takes precedence over parity error
                  if (win_shift != STOP_PAT) begin
                     frame_error_d = 1'b1;
                     err_code_d    = ERR_STOP;
                  end else if (par_err_q) begin
                     frame_error_d = 1'b1;
                     err_code_d    = ERR_PARITY;
                  end else begin
                     frame_valid_d = 1'b1;
                     payload_d     = shift_q;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // expire never coincides with BitValid, so no frame result is overridden
      if (expire) begin
         state_d       = StIdle;
         win_d         = '0;
         cnt_d         = '0;
         frame_error_d = 1'b1;
         err_code_d    = ERR_TIMEOUT;
      end
   end

   // State and output registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q       <= StIdle;
         win_q         <= '0;
         shift_q       <= '0;
         payload_q     <= '0;
         cnt_q         <= '0;
         par_err_q     <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
         err_code_q    <= '0;
      end else begin
         state_q       <= state_d;
         win_q         <= win_d;
         shift_q       <= shift_d;
         payload_q     <= payload_d;
         cnt_q         <= cnt_d;
         par_err_q     <= par_err_d;
         frame_valid_q <= frame_valid_d;
         frame_error_q <= frame_error_d;
         err_code_q    <= err_code_d;
      end
   end

   assign Client     = payload_q[CLIENT_LSB   +: CLIENT_W];
   assign Duration   = payload_q[DURATION_LSB +: DURATION_W];
   assign ValueToPay = payload_q[VALUE_LSB    +: VALUE_W];
   assign Excess5    = payload_q[EXCESS_LSB   +: EXCESS_W];
   assign FrameValid = frame_valid_q;
   assign FrameError = frame_error_q;
   assign ErrorCode  = err_code_q;
   assign Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_barcode_ticket_reader.sv
// Scoreboarded bench for barcode_ticket_reader: directed frames plus random frames.
module tb_barcode_ticket_reader;

   localparam int unsigned T = 1000;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b1;
   logic       BitIn = 1'b0;
   logic       BitValid = 1'b0;
   logic [1:0] Client;
   logic [2:0] Duration;
   logic [4:0] ValueToPay;
   logic [5:0] Excess5;
   logic       FrameValid;
   logic       FrameError;
   logic [1:0] ErrorCode;
   logic       Busy;

   barcode_ticket_reader #(
      .TIMEOUT_CYC (T)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .BitIn      (BitIn),
      .BitValid   (BitValid),
      .Client     (Client),
      .Duration   (Duration),
      .ValueToPay (ValueToPay),
      .Excess5    (Excess5),
      .FrameValid (FrameValid),
      .FrameError (FrameError),
      .ErrorCode  (ErrorCode),
      .Busy       (Busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit          is_err;
      logic [1:0]  code;
      logic [15:0] fields;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] last_good = '0;
   logic [1:0]  last_code = '0;
   int          n_err = 0;
   int          n_chk = 0;
   int          gap_max = 2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: decide the outcome of a complete frame from the frame rules
   task automatic expect_frame(input logic [15:0] p, input logic par, input logic [2:0] stop);
      exp_t e;
      if (stop != 3'b101) begin
         last_code = 2'b10;
         e.is_err  = 1'b1;
      end else if (par != (^p)) begin
         last_code = 2'b01;
         e.is_err  = 1'b1;
      end else begin
         last_good = p;
         e.is_err  = 1'b0;
      end
      e.code   = last_code;
      e.fields = last_good;
      exp_q.push_back(e);
   endtask

   task automatic expect_timeout();
      exp_t e;
      last_code = 2'b11;
      e.is_err  = 1'b1;
      e.code    = last_code;
      e.fields  = last_good;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; strobes one bit, returns at a later negedge
   task automatic drive(input logic b);
      BitIn    = b;
      BitValid = 1'b1;
      @(negedge Clk);
      BitValid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge Clk);
   endtask

   task automatic send_bits(input logic [22:0] f, input int from, input int to);
      for (int i = from; i <= to; i++) drive(f[22-i]);
   endtask

   task automatic send_frame(input logic [15:0] p, input logic par, input logic [2:0] stop,
                             input int noise_n, input logic noise_v);
      logic [22:0] f;
      f = {3'b101, p, par, stop};
      expect_frame(p, par, stop);
      for (int i = 0; i < noise_n; i++) drive(noise_v);
      send_bits(f, 0, 2);
      check("busy_after_start", Busy, 1);
      send_bits(f, 3, 22);
      repeat (3) @(negedge Clk);
      check("idle_after_frame", Busy, 0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_pulses"}, {FrameValid, FrameError}, 0);
      check({name, "_code"}, ErrorCode, 0);
      check({name, "_fields"}, {Client, Duration, ValueToPay, Excess5}, 0);
      check({name, "_busy"}, Busy, 0);
   endtask

   // Monitor: pop and compare whenever the DUT presents a frame result
   always @(negedge Clk) begin
      exp_t e;
      if (Reset_n && (FrameValid || FrameError)) begin
         check("pulse_exclusive", FrameValid & FrameError, 0);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_pulse: FrameValid=%0b FrameError=%0b, none expected at %0t",
                     FrameValid, FrameError, $time);
         end else begin
            e = exp_q.pop_front();
            check("frame_error", FrameError, e.is_err);
            check("frame_valid", FrameValid, !e.is_err);
            check("error_code", ErrorCode, e.code);
            check("client", Client, e.fields[15:14]);
            check("duration", Duration, e.fields[13:11]);
            check("value", ValueToPay, e.fields[10:6]);
            check("excess", Excess5, e.fields[5:0]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, still pending %0d", exp_q.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [22:0] f;
      logic [15:0] p;
      logic        par;
      logic [2:0]  stop;

      #2 Reset_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      // Good frame, then parity error and stop guard error on the same payload
      send_frame(16'h9100, 1'b1, 3'b101, 0, 1'b0);
      send_frame(16'h9100, 1'b0, 3'b101, 0, 1'b0);
      send_frame(16'h9100, 1'b1, 3'b100, 0, 1'b0);
      // Leading noise bit: 1,1,0,1 finds start on the overlapping window
      send_frame(16'hFFFF, 1'b0, 3'b101, 1, 1'b1);

      // Stall after 8 payload bits: error exactly T edges after the last strobe
      gap_max = 0;
      p = 16'hA5C3;
      f = {3'b101, p, ^p, 3'b101};
      expect_timeout();
      send_bits(f, 0, 10);
      repeat (T - 1) @(negedge Clk);
      check("timeout_not_early", FrameError, 0);
      @(negedge Clk);
      check("timeout_fires", FrameError, 1);
      check("timeout_code", ErrorCode, 2'b11);
      repeat (2) @(negedge Clk);
      check("timeout_idle", Busy, 0);

      // Strobe on the expiry cycle keeps the frame alive
      expect_frame(p, ^p, 3'b101);
      send_bits(f, 0, 10);
      repeat (T - 2) @(negedge Clk);
      check("stall_still_busy", Busy, 1);
      @(negedge Clk);
      send_bits(f, 11, 22);
      repeat (3) @(negedge Clk);
      gap_max = 2;

      // Reset mid-payload discards the partial frame and clears outputs
      p = 16'h1234;
      f = {3'b101, p, ^p, 3'b101};
      send_bits(f, 0, 8);
      Reset_n = 1'b0;
      #1 check_all_zero("midframe_reset");
      last_good = '0;
      last_code = '0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      send_frame(16'h4321, ^16'h4321, 3'b101, 0, 1'b0);

      // Random frames with occasional parity and stop guard faults
      for (int n = 0; n < 40; n++) begin
         p   = 16'($urandom);
         par = ($urandom_range(0, 4) == 0) ? ~(^p) : (^p);
         if ($urandom_range(0, 4) == 0) begin
            stop = 3'($urandom_range(0, 6));
            if (stop >= 3'd5) stop = stop + 3'd1;
         end else begin
            stop = 3'b101;
         end
         send_frame(p, par, stop, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge Clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
